// File: rtl/du_program_loader.sv
// du_program_loader: receive-side stage of the debug unit.
// Decodes UART bytes into an instruction count, little-endian instructions
// written to instruction memory, and operation-mode bytes once loading ends.
// Optional build macro DU_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module du_program_loader #(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned N_BYTES    = 4,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [N_BITS-1:0]     i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_restart,
  input  logic                  i_mode_req,
  output logic [N_BITS-1:0]     o_instr_count,
  output logic                  o_count_ready,
  output logic [NB_DATA-1:0]    o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_addr,
  output logic                  o_instr_we,
  output logic                  o_load_done,
  output logic [N_BITS-1:0]     o_mode,
  output logic                  o_mode_valid,
  output logic                  o_chk_err
);

  localparam int unsigned BCW       = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned MAX_COUNT = 2 ** ADDR_WIDTH;

`ifdef DU_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_COUNT, S_BYTES, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_COUNT, S_BYTES, S_WRITE, S_DONE} state_t;
`endif

  state_t                  state, state_n;
  logic [BCW-1:0]          byte_cnt, byte_cnt_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n;
  logic                    pend_valid, pend_valid_n;
  logic [N_BITS-1:0]       pend_data, pend_data_n;
  logic [N_BITS-1:0]       count_q, count_n;
  logic                    count_ready_q, count_ready_n;
  logic [NB_DATA-1:0]      instr_q, instr_n;
  logic [N_BITS-1:0]       mode_q, mode_n;
  logic                    mode_valid_q, mode_valid_n;

  logic                    byte_avail;
  logic [N_BITS-1:0]       byte_val;
  logic                    last_instr;
  logic [N_BITS-1:0]       sat_count;

`ifdef DU_LOADER_CHECKSUM_EN
  logic [N_BITS-1:0]       chk_acc, chk_acc_n;
  logic                    chk_err_q, chk_err_n;
`endif

  // A byte parked during the write cycle is always consumed before the live strobe
  assign byte_avail = pend_valid | i_rx_done;
  assign byte_val   = pend_valid ? pend_data : i_rx_data;
  assign last_instr = ((32'(addr) + 32'd1) == 32'(count_q));
  assign sat_count  = (32'(i_rx_data) > MAX_COUNT) ? N_BITS'(MAX_COUNT) : i_rx_data;

  // State and datapath registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= S_COUNT;
      byte_cnt      <= '0;
      addr          <= '0;
      pend_valid    <= 1'b0;
      pend_data     <= '0;
      count_q       <= '0;
      count_ready_q <= 1'b0;
      instr_q       <= '0;
      mode_q        <= '0;
      mode_valid_q  <= 1'b0;
`ifdef DU_LOADER_CHECKSUM_EN
      chk_acc       <= '0;
      chk_err_q     <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      byte_cnt      <= byte_cnt_n;
      addr          <= addr_n;
      pend_valid    <= pend_valid_n;
      pend_data     <= pend_data_n;
      count_q       <= count_n;
      count_ready_q <= count_ready_n;
      instr_q       <= instr_n;
      mode_q        <= mode_n;
      mode_valid_q  <= mode_valid_n;
`ifdef DU_LOADER_CHECKSUM_EN
      chk_acc       <= chk_acc_n;
      chk_err_q     <= chk_err_n;
`endif
    end
  end

  // Next-state and datapath update; restart overrides every state
  always_comb begin
    state_n       = state;
    byte_cnt_n    = byte_cnt;
    addr_n        = addr;
    pend_valid_n  = pend_valid;
    pend_data_n   = pend_data;
    count_n       = count_q;
    count_ready_n = count_ready_q;
    instr_n       = instr_q;
    mode_n        = mode_q;
    mode_valid_n  = 1'b0;
`ifdef DU_LOADER_CHECKSUM_EN
    chk_acc_n     = chk_acc;
    chk_err_n     = chk_err_q;
`endif

    case (state)
      S_COUNT: begin
        if (i_rx_done) begin
          count_n       = sat_count;
          count_ready_n = 1'b1;
          addr_n        = '0;
          byte_cnt_n    = '0;
`ifdef DU_LOADER_CHECKSUM_EN
          chk_acc_n     = '0;
`endif
          state_n       = (sat_count == '0) ? S_DONE : S_BYTES;
        end
      end
      S_BYTES: begin
        if (byte_avail) begin
          instr_n[N_BITS*byte_cnt +: N_BITS] = byte_val;
`ifdef DU_LOADER_CHECKSUM_EN
          chk_acc_n = chk_acc ^ byte_val;
`endif
          // When the parked byte is used, a simultaneous live strobe takes its place
          pend_valid_n = pend_valid & i_rx_done;
          if (pend_valid && i_rx_done) begin
            pend_data_n = i_rx_data;
          end
          if (32'(byte_cnt) == (N_BYTES - 1)) begin
            state_n = S_WRITE;
          end else begin
            byte_cnt_n = byte_cnt + BCW'(1);
          end
        end
      end
      S_WRITE: begin
        byte_cnt_n = '0;
        if (i_rx_done) begin
          pend_valid_n = 1'b1;
          pend_data_n  = i_rx_data;
        end
        if (last_instr) begin
`ifdef DU_LOADER_CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_DONE;
`endif
        end else begin
          addr_n  = addr + ADDR_WIDTH'(1);
          state_n = S_BYTES;
        end
      end
`ifdef DU_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_avail) begin
          if (byte_val != chk_acc) begin
            chk_err_n = 1'b1;
          end
          pend_valid_n = 1'b0;
          state_n      = S_DONE;
        end
      end
`endif
      S_DONE: begin
        pend_valid_n = 1'b0;
        if (i_rx_done && i_mode_req) begin
          mode_n       = i_rx_data;
          mode_valid_n = 1'b1;
        end
      end
      default: begin
        state_n = S_COUNT;
      end
    endcase

    if (i_restart) begin
      state_n       = S_COUNT;
      count_n       = count_q;
      count_ready_n = 1'b0;
      addr_n        = '0;
      byte_cnt_n    = '0;
      pend_valid_n  = 1'b0;
      pend_data_n   = pend_data;
      instr_n       = instr_q;
      mode_n        = mode_q;
      mode_valid_n  = 1'b0;
`ifdef DU_LOADER_CHECKSUM_EN
      chk_acc_n     = chk_acc;
      chk_err_n     = 1'b0;
`endif
    end
  end

  assign o_instr_count = count_q;
  assign o_count_ready = count_ready_q;
  assign o_instr       = instr_q;
  assign o_instr_addr  = addr;
  assign o_instr_we    = (state == S_WRITE);
  assign o_load_done   = (state == S_DONE);
  assign o_mode        = mode_q;
  assign o_mode_valid  = mode_valid_q;
`ifdef DU_LOADER_CHECKSUM_EN
  assign o_chk_err     = chk_err_q;
`else
  assign o_chk_err     = 1'b0;
`endif

endmodule
